// File: rtl/otbn_pq_pkg.sv
// Shared PQ datapath types: write-back collector entry state and staging-entry layout.
package otbn_pq_pkg;

  localparam int PqWlen   = 256;
  localparam int PqLen    = 32;
  localparam int PqNLanes = PqWlen / PqLen;
  localparam int PqWdrAw  = 5;

  typedef enum logic [1:0] {
    WbFree = 2'd0,
    WbFill = 2'd1,
    WbPend = 2'd2
  } pq_wb_state_e;

  typedef struct packed {
    pq_wb_state_e          state;
    logic [PqWdrAw-1:0]    dest;
    logic [PqWlen-1:0]     data;
    logic [PqNLanes-1:0]   mask;
  } pq_wb_entry_t;

endpackage

// File: rtl/otbn_pq_wb_entry.sv
// One write-back staging entry: lane merge, close detection and clear on drain.
module otbn_pq_wb_entry
  import otbn_pq_pkg::*;
#(
  parameter int PQLEN  = PqLen,
  parameter int NLANES = PqNLanes,
  parameter int WdrAw  = PqWdrAw
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       acc,
  input  logic                       flush,
  input  logic                       force_close,
  input  logic                       clear,
  input  logic [$clog2(NLANES)-1:0]  lane,
  input  logic [PQLEN-1:0]           value,
  input  logic [WdrAw-1:0]           wdr,
  output pq_wb_state_e               state,
  output logic [WdrAw-1:0]           dest,
  output logic [PQLEN*NLANES-1:0]    data,
  output logic [NLANES-1:0]          mask,
  output logic                       closing,
  output logic                       dup
);

  logic [NLANES-1:0]       mask_nxt;
  logic [PQLEN*NLANES-1:0] data_nxt;

  // A FREE entry holds zeroed data, so merging into it and merging into FILL are identical.
  always_comb begin
    mask_nxt       = (state == WbFree) ? '0 : mask;
    mask_nxt[lane] = 1'b1;
    data_nxt       = data;
    data_nxt[lane*PQLEN +: PQLEN] = value;
    dup            = acc && (state == WbFill) && mask[lane];
    if (acc) begin
      closing = (&mask_nxt) || flush;
    end else begin
      closing = flush && (state == WbFill);
    end
  end

  // Entry state, destination and lane data.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear) begin
      state <= WbFree;
      dest  <= '0;
      data  <= '0;
      mask  <= '0;
    end else if (force_close) begin
      state <= WbPend;
    end else if (acc) begin
      state <= closing ? WbPend : WbFill;
      dest  <= wdr;
      data  <= data_nxt;
      mask  <= mask_nxt;
    end else if (closing) begin
      state <= WbPend;
    end
  end

endmodule

// File: rtl/otbn_pq_wb_collector.sv
// PQ write-back collector: merges lane results into two ping-pong entries and
// issues each completed entry as one lane-masked WDR write.
module otbn_pq_wb_collector
  import otbn_pq_pkg::*;
#(
  parameter int PQLEN  = PqLen,
  parameter int NLANES = PqNLanes,
  parameter int WdrAw  = PqWdrAw
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [PQLEN-1:0]           res_data_i,
  input  logic [$clog2(NLANES)-1:0]  res_lane_i,
  input  logic [WdrAw-1:0]           res_wdr_i,
  input  logic                       flush_i,
  output logic                       wr_en_o,
  input  logic                       wr_ready_i,
  output logic [WdrAw-1:0]           wr_addr_o,
  output logic [PQLEN*NLANES-1:0]    wr_data_o,
  output logic [NLANES-1:0]          wr_lane_en_o,
  output logic                       dup_o,
  output logic                       idle_o
);

  pq_wb_state_e            st   [2];
  logic [WdrAw-1:0]        dest [2];
  logic [PQLEN*NLANES-1:0] data [2];
  logic [NLANES-1:0]       mask [2];
  logic [1:0]              closing, dup_s, acc_e, flush_e, force_e, clear_e;

  logic fill_ptr, drain_ptr, dup_q;
  logic mismatch, accept, switch_entry, target, drain_hs;

  assign mismatch     = (st[fill_ptr] == WbFill) && (res_wdr_i != dest[fill_ptr]);
  assign res_ready_o  = rst_ni && (st[fill_ptr] != WbPend) &&
                        !(mismatch && (st[~fill_ptr] != WbFree));
  assign accept       = res_valid_i && res_ready_o;
  assign switch_entry = accept && mismatch;
  // A mismatching result starts the other entry, which is guaranteed FREE here.
  assign target       = fill_ptr ^ switch_entry;
  assign drain_hs     = wr_en_o && wr_ready_i;

  for (genvar i = 0; i < 2; i++) begin : g_entry
    assign acc_e[i]   = accept && (target == 1'(i));
    assign flush_e[i] = flush_i && (target == 1'(i));
    assign force_e[i] = switch_entry && (fill_ptr == 1'(i));
    assign clear_e[i] = drain_hs && (drain_ptr == 1'(i));

    otbn_pq_wb_entry #(
      .PQLEN  (PQLEN),
      .NLANES (NLANES),
      .WdrAw  (WdrAw)
    ) u_entry (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .acc         (acc_e[i]),
      .flush       (flush_e[i]),
      .force_close (force_e[i]),
      .clear       (clear_e[i]),
      .lane        (res_lane_i),
      .value       (res_data_i),
      .wdr         (res_wdr_i),
      .state       (st[i]),
      .dest        (dest[i]),
      .data        (data[i]),
      .mask        (mask[i]),
      .closing     (closing[i]),
      .dup         (dup_s[i])
    );
  end

  // Fill/drain pointers and the duplicate-lane pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fill_ptr  <= 1'b0;
      drain_ptr <= 1'b0;
      dup_q     <= 1'b0;
    end else begin
      fill_ptr  <= target ^ closing[target];
      drain_ptr <= drain_ptr ^ drain_hs;
      dup_q     <= dup_s[target];
    end
  end

  assign wr_en_o      = (st[drain_ptr] == WbPend);
  assign wr_addr_o    = dest[drain_ptr];
  assign wr_data_o    = data[drain_ptr];
  assign wr_lane_en_o = mask[drain_ptr];
  assign dup_o        = dup_q;
  assign idle_o       = (st[0] == WbFree) && (st[1] == WbFree);

endmodule

// File: tb/tb_otbn_pq_wb_collector.sv
// Randomized bench for the PQ write-back collector against a queue-based reference model.
module tb_otbn_pq_wb_collector;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         res_valid = 1'b0;
  logic         res_ready;
  logic [31:0]  res_data = 32'd0;
  logic [2:0]   res_lane = 3'd0;
  logic [4:0]   res_wdr = 5'd0;
  logic         flush = 1'b0;
  logic         wr_en;
  logic         wr_ready = 1'b0;
  logic [4:0]   wr_addr;
  logic [255:0] wr_data;
  logic [7:0]   wr_lane_en;
  logic         dup;
  logic         idle;

  always #5 clk = ~clk;

  otbn_pq_wb_collector dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .res_valid_i  (res_valid),
    .res_ready_o  (res_ready),
    .res_data_i   (res_data),
    .res_lane_i   (res_lane),
    .res_wdr_i    (res_wdr),
    .flush_i      (flush),
    .wr_en_o      (wr_en),
    .wr_ready_i   (wr_ready),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .wr_lane_en_o (wr_lane_en),
    .dup_o        (dup),
    .idle_o       (idle)
  );

  // Reference model: at most one open word plus a FIFO of closed words awaiting write.
  typedef struct {
    logic [4:0]   dest;
    logic [255:0] data;
    logic [7:0]   mask;
  } wr_t;

  wr_t         pend[$];
  bit          open_v;
  logic [4:0]  open_dest;
  logic [31:0] open_lane[8];
  logic [7:0]  open_mask;
  bit          exp_dup;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic close_open();
    wr_t w;
    w.dest = open_dest;
    w.mask = open_mask;
    w.data = '0;
    for (int k = 0; k < 8; k++)
      if (open_mask[k]) w.data[32*k +: 32] = open_lane[k];
    pend.push_back(w);
    open_v = 1'b0;
  endtask

  task automatic model_clear();
    pend.delete();
    open_v  = 1'b0;
    exp_dup = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    res_valid = 1'b1;
    res_lane  = 3'($urandom_range(0, 7));
    res_wdr   = 5'($urandom_range(0, 3));
    flush     = 1'b0;
    wr_ready  = 1'b1;
    #1;
    check("ready_in_reset", 256'(res_ready), 256'(1'b0));
    model_clear();
  endtask

  task automatic step(input bit v, input int lane, input int wdr, input logic [31:0] d,
                      input bit fl, input bit wrr);
    bit mism, exp_ready, hs, acc;
    @(negedge clk);
    rst_n     = 1'b1;
    res_valid = v;
    res_lane  = 3'(lane);
    res_wdr   = 5'(wdr);
    res_data  = d;
    flush     = fl;
    wr_ready  = wrr;
    #1;
    mism      = open_v && (5'(wdr) != open_dest);
    exp_ready = (pend.size() < 2) && !(mism && pend.size() == 1);
    check("ready", 256'(res_ready), 256'(exp_ready));
    check("wr_en", 256'(wr_en), 256'(pend.size() > 0));
    if (pend.size() > 0) begin
      check("wr_addr", 256'(wr_addr), 256'(pend[0].dest));
      check("wr_data", wr_data, pend[0].data);
      check("wr_mask", 256'(wr_lane_en), 256'(pend[0].mask));
    end
    check("dup", 256'(dup), 256'(exp_dup));
    check("idle", 256'(idle), 256'(!open_v && pend.size() == 0));

    hs = (pend.size() > 0) && wrr;
    if (hs) void'(pend.pop_front());
    acc = v && exp_ready;
    exp_dup = 1'b0;
    if (acc) begin
      if (mism) close_open();
      if (!open_v) begin
        open_v    = 1'b1;
        open_dest = 5'(wdr);
        open_mask = 8'h00;
      end
      if (open_mask[lane]) exp_dup = 1'b1;
      open_mask[lane] = 1'b1;
      open_lane[lane] = d;
    end
    if (open_v && (open_mask == 8'hFF || fl)) close_open();
  endtask

  initial begin
    model_clear();
    do_reset();
    do_reset();

    // Full word to WDR 3.
    for (int k = 0; k < 8; k++) step(1'b1, k, 3, 32'h100 + 32'(k), 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);

    // Partial word plus flush.
    step(1'b1, 2, 7, 32'hA, 1'b0, 1'b1);
    step(1'b1, 5, 7, 32'hB, 1'b0, 1'b1);
    step(1'b0, 0, 7, 32'd0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b1, 1'b1);

    // Destination switch.
    step(1'b1, 0, 1, 32'h1, 1'b0, 1'b1);
    step(1'b1, 1, 1, 32'h2, 1'b0, 1'b1);
    step(1'b1, 0, 2, 32'h3, 1'b0, 1'b1);
    step(1'b0, 0, 2, 32'd0, 1'b0, 1'b1);
    step(1'b0, 0, 2, 32'd0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);

    // Backpressure: two full words stall the third result until the first drains.
    for (int k = 0; k < 8; k++) step(1'b1, k, 4, 32'h400 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, k, 5, 32'h500 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 0, 6, 32'h600, 1'b0, 1'b0);
    step(1'b1, 0, 6, 32'h600, 1'b0, 1'b1);
    step(1'b1, 0, 6, 32'h600, 1'b0, 1'b1);
    step(1'b0, 0, 6, 32'd0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);

    // Duplicate lane.
    step(1'b1, 3, 0, 32'h11, 1'b0, 1'b1);
    step(1'b1, 3, 0, 32'h22, 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);

    // Reset mid-fill, then a normal full word.
    for (int k = 0; k < 4; k++) step(1'b1, k, 9, 32'h900 + 32'(k), 1'b0, 1'b1);
    do_reset();
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 7 - k, 12, 32'hC00 + 32'(k), 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 32'd0, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 99) < 70, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           32'($urandom), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
